mem_access_stage: RTL

MEM stage of the 5-stage RV32I pipeline. Consumes the EX/MEM pipeline register outputs, performs load/store accesses on a data-memory bus with a req/ready handshake, stalls upstream stages while an access is outstanding, and drives the MEM/WB-facing registered outputs. Handles byte/half/word sizing, load sign/zero extension and misalignment detection.

---
 rtl/mem_access_stage_if.sv | 20 ++
 rtl/mem_access_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [3:0]  dmem_be_out;
  logic        dmem_ready_in;
  logic [31:0] dmem_rdata_in;

  modport master (
    output dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_be_out,
    input  dmem_ready_in, dmem_rdata_in
  );

  modport slave (
    input  dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_be_out,
    output dmem_ready_in, dmem_rdata_in
  );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: sized load/store over a req/ready data bus, stalls upstream
// while an access is outstanding, and registers the MEM/WB results.
module mem_access_stage (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               alu_result_in,
  input  logic [31:0]               rs2_data_in,
  input  logic [4:0]                rd_in,
  input  logic                      reg_write_in,
  input  logic                      mem_write_in,
  input  logic                      mem_read_in,
  input  logic                      mem_to_reg_in,
  input  logic [2:0]                funct3_in,
  output logic                      stall_out,
  mem_access_stage_if.master        dmem,
  output logic [31:0]               wb_alu_result_out,
  output logic [31:0]               wb_mem_data_out,
  output logic [4:0]                wb_rd_out,
  output logic                      wb_reg_write_out,
  output logic                      wb_mem_to_reg_out,
  output logic                      mem_err_out
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned BW = DW / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]   be_q, be_d;
  logic [DW-1:0]   load_q, load_d;
  logic [DW-1:0]   wb_alu_q, wb_alu_d;
  logic [DW-1:0]   wb_data_q, wb_data_d;
  logic [RW-1:0]   wb_rd_q, wb_rd_d;
  logic            wb_rw_q, wb_rw_d;
  logic            wb_m2r_q, wb_m2r_d;
  logic            err_q, err_d;

  logic            mem_op;
  logic            is_store;
  logic            illegal;
  logic [BW-1:0]   lane_be;
  logic [DW-1:0]   lane_wdata;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [DW-1:0]   load_ext;

  // Access decode: legality, store lane steering and load extraction.
  always_comb begin
    mem_op     = mem_read_in | mem_write_in;
    is_store   = mem_write_in;
    illegal    = 1'b0;
    lane_be    = {BW{1'b1}};
    lane_wdata = '0;
    byte_sel   = 8'h00;
    half_sel   = 16'h0000;
    load_ext   = dmem.dmem_rdata_in;

    case (funct3_in)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = alu_result_in[0];
      3'b010:         illegal = (alu_result_in[1:0] != 2'b00);
      default:        illegal = 1'b1;
    endcase

    if (is_store) begin
      case (funct3_in[1:0])
        2'b00: begin
          lane_be    = BW'(4'b0001 << alu_result_in[1:0]);
          lane_wdata = {4{rs2_data_in[7:0]}};
        end
        2'b01: begin
          lane_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
          lane_wdata = {2{rs2_data_in[15:0]}};
        end
        default: begin
          lane_be    = {BW{1'b1}};
          lane_wdata = rs2_data_in;
        end
      endcase
    end

    case (alu_result_in[1:0])
      2'b00:   byte_sel = dmem.dmem_rdata_in[7:0];
      2'b01:   byte_sel = dmem.dmem_rdata_in[15:8];
      2'b10:   byte_sel = dmem.dmem_rdata_in[23:16];
      default: byte_sel = dmem.dmem_rdata_in[31:24];
    endcase
    half_sel = alu_result_in[1] ? dmem.dmem_rdata_in[31:16] : dmem.dmem_rdata_in[15:0];

    case (funct3_in)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h000000, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0000, half_sel};
      default: load_ext = dmem.dmem_rdata_in;
    endcase
  end

  // Next-state, bus and MEM/WB logic; default is hold bus, bubble MEM/WB.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    load_d    = load_q;
    wb_alu_d  = '0;
    wb_data_d = '0;
    wb_rd_d   = '0;
    wb_rw_d   = 1'b0;
    wb_m2r_d  = 1'b0;
    err_d     = 1'b0;
    stall_out = 1'b0;

    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          wb_alu_d = alu_result_in;
          wb_rd_d  = rd_in;
          wb_rw_d  = reg_write_in & (rd_in != 5'd0);
          wb_m2r_d = mem_to_reg_in;
        end else if (illegal) begin
          err_d = 1'b1;
        end else begin
          stall_out = 1'b1;
          req_d     = 1'b1;
          we_d      = is_store;
          addr_d    = {alu_result_in[31:2], 2'b00};
          wdata_d   = lane_wdata;
          be_d      = lane_be;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        stall_out = 1'b1;
        if (req_q && dmem.dmem_ready_in) begin
          req_d   = 1'b0;
          load_d  = is_store ? '0 : load_ext;
          state_d = DONE;
        end
      end
      DONE: begin
        wb_alu_d  = alu_result_in;
        wb_data_d = load_q;
        wb_rd_d   = rd_in;
        wb_rw_d   = reg_write_in & (rd_in != 5'd0);
        wb_m2r_d  = mem_to_reg_in;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      load_q    <= '0;
      wb_alu_q  <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_rw_q   <= 1'b0;
      wb_m2r_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      load_q    <= load_d;
      wb_alu_q  <= wb_alu_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_rw_q   <= wb_rw_d;
      wb_m2r_q  <= wb_m2r_d;
      err_q     <= err_d;
    end
  end

  assign dmem.dmem_req_out   = req_q;
  assign dmem.dmem_we_out    = we_q;
  assign dmem.dmem_addr_out  = addr_q;
  assign dmem.dmem_wdata_out = wdata_q;
  assign dmem.dmem_be_out    = be_q;

  assign wb_alu_result_out = wb_alu_q;
  assign wb_mem_data_out   = wb_data_q;
  assign wb_rd_out         = wb_rd_q;
  assign wb_reg_write_out  = wb_rw_q;
  assign wb_mem_to_reg_out = wb_m2r_q;
  assign mem_err_out       = err_q;

endmodule
